// File: rtl/fm_peak_detector.sv
// Windowed peak-magnitude detector for demodulated FM audio feeding the SPI slave.
// Define FM_PEAK_OVERRUN_CNT_EN to add the saturating overrun_cnt output.
module fm_peak_detector #(
  parameter int SAMPLE_W = 12,
  parameter int WIN_LEN  = 256,
  parameter int THRESH   = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic                       sample_valid,
  input  logic                       byte_received,
  output logic                       pk_dtc_flag,
  output logic [7:0]                 data_8bit,
  output logic                       win_done
`ifdef FM_PEAK_OVERRUN_CNT_EN
  ,
  output logic [7:0]                 overrun_cnt
`endif
);

  localparam int MW = SAMPLE_W - 1;
  localparam int CW = $clog2(WIN_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(WIN_LEN - 1);
  localparam logic [7:0] THR = 8'(THRESH);

  typedef enum logic {
    ARMED   = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t state;
  state_t state_n;

  logic [CW-1:0]       cnt;
  logic [MW-1:0]       peak;
  logic [SAMPLE_W-1:0] neg;
  logic [MW-1:0]       mag;
  logic [MW-1:0]       final_peak;
  logic [7:0]          pbyte;
  logic                hit;
  logic                win_end;
  logic                load;

  assign neg = '0 - sample;

  // Only the most negative input still has its sign bit set after negation.
  always_comb begin
    mag = sample[MW-1:0];
    if (sample[SAMPLE_W-1]) begin
      if (neg[SAMPLE_W-1]) mag = '1;
      else                 mag = neg[MW-1:0];
    end
  end

  assign final_peak = (mag > peak) ? mag : peak;
  assign pbyte      = final_peak[MW-1 -: 8];
  assign hit        = (pbyte >= THR);
  assign win_end    = sample_valid && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      peak     <= '0;
      win_done <= 1'b0;
    end else begin
      win_done <= win_end;
      if (sample_valid) begin
        if (win_end) begin
          cnt  <= '0;
          peak <= '0;
        end else begin
          cnt  <= cnt + CW'(1);
          peak <= final_peak;
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    unique case (state)
      ARMED: begin
        if (win_end && hit) begin
          load    = 1'b1;
          state_n = PENDING;
        end
      end
      PENDING: begin
        if (win_end && hit) begin
          load = 1'b1;
        end else if (byte_received) begin
          state_n = ARMED;
        end
      end
      default: state_n = ARMED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARMED;
      data_8bit <= '0;
    end else begin
      state <= state_n;
      if (load) data_8bit <= pbyte;
    end
  end

  assign pk_dtc_flag = (state == PENDING);

`ifdef FM_PEAK_OVERRUN_CNT_EN
  logic overrun;

  // A same-edge acknowledge means the old byte was consumed: not an overrun.
  assign overrun = (state == PENDING) && win_end && hit && !byte_received;

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_cnt <= '0;
    end else if (overrun && (overrun_cnt != 8'hFF)) begin
      overrun_cnt <= overrun_cnt + 8'd1;
    end
  end
`else
  // Overrun tracking not built.
`endif

endmodule

// File: doc/fm_peak_detector.md
Name: fm_peak_detector

Overview:
- Sits directly upstream of the SPI slave.
- Consumes signed demodulated FM audio samples and tracks the peak absolute amplitude over fixed windows of WIN_LEN valid samples.
- At each window end it publishes an 8-bit peak byte on data_8bit and raises pk_dtc_flag if the peak meets THRESH.
- The flag is held until the SPI slave's byte_received pulse acknowledges that the byte has been shifted out.

Parameters:
- SAMPLE_W, 12: width of the signed input sample, two's complement.
- WIN_LEN, 256: valid samples per detection window; legal range 2..65535.
- THRESH, 64: minimum 8-bit peak byte that raises pk_dtc_flag.

Ports:
- clk  input  1  system clock; the single clock domain.
- rst  input  1  synchronous, active-high reset.
- sample  input  SAMPLE_W  signed demodulated sample.
- sample_valid  input  1  qualifies sample; one sample accepted per clk when high.
- byte_received  input  1  one-cycle acknowledge pulse from the SPI slave.
- pk_dtc_flag  output  1  peak byte pending transmission.
- data_8bit  output  8  published peak byte.
- win_done  output  1  one-cycle pulse at every window end, whether or not the threshold was met.

Behaviour:
- Reset (rst high at a clk edge) clears the following; reset mid-window discards the partial window:
  - pk_dtc_flag, data_8bit and win_done to 0.
  - Sample counter and running peak to 0.
  - State to ARMED.
- Magnitude:
  - mag = |sample| as an unsigned (SAMPLE_W-1)-bit value.
  - The most negative input saturates to 2^(SAMPLE_W-1)-1; for example, -2048 gives 2047.
- Running peak:
  - Updated only on cycles with sample_valid=1: peak <= max(peak, mag).
  - Counter increments on each valid sample.
  - sample_valid=0 holds all window state.
- Window end: the valid sample that brings the count to WIN_LEN.
  - On that edge the final peak includes the current sample.
  - pbyte = final_peak[SAMPLE_W-2 : SAMPLE_W-9], the top 8 magnitude bits.
  - Counter and running peak clear to 0 on the same edge, so the next window starts with no gap.
  - win_done is high for exactly the following cycle (registered, latency 1).
- Publish FSM (the state is pk_dtc_flag itself):
  - ARMED (flag=0):
    - Window end with pbyte >= THRESH: data_8bit <= pbyte, flag <= 1, go to PENDING.
    - Window end below threshold: data_8bit unchanged, stay in ARMED.
    - byte_received while ARMED is ignored.
  - PENDING (flag=1):
    - byte_received with no window end: flag <= 0, go to ARMED; data_8bit holds its value.
    - Window end with pbyte >= THRESH and no byte_received (overrun): data_8bit <= pbyte (freshest wins), flag stays 1.
    - Window end below threshold and no byte_received: no change.
    - Window end with pbyte >= THRESH and byte_received on the same edge: new byte published, flag stays 1, not counted as an overrun.
    - Window end below threshold and byte_received on the same edge: flag <= 0.
- Output timing:
  - data_8bit and pk_dtc_flag are registered and change only on window-end or acknowledge edges.
  - They are glitch-free for the SPI slave's byte-boundary sampling.
- Arithmetic:
  - Counter width is clog2(WIN_LEN+1).
  - Counter wraps to 0 only at WIN_LEN and never overflows.
  - All comparisons are unsigned.

Optional Feature:
- Macro: FM_PEAK_OVERRUN_CNT_EN.
- When defined:
  - Adds output port overrun_cnt, 8 bits: count of overruns (window-end publishes while PENDING without a same-edge byte_received).
  - The count saturates at 255.
  - Reset clears it to 0; it is read-only, cleared only by reset.
- When undefined: the port and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Ramp 1 (WIN_LEN=256, SAMPLE_W=12): samples 0..255, all valid -> win_done pulse one cycle after the 256th sample; peak 255 gives pbyte 255>>3=31 < 64 -> flag stays 0 and data_8bit stays 0.
- Single spike: one sample of -2048, rest 0 -> data_8bit=0xFF, pk_dtc_flag=1 one cycle after the window end; then byte_received pulse -> flag=0 next cycle and data_8bit stays 0xFF.
- Gapped valid: the 256 valid samples interleaved with random sample_valid=0 cycles, holding large values during the invalid cycles -> invalid samples are ignored and win_done fires after exactly 256 valid samples.
- Overrun: two consecutive windows with peaks 1000 then 600 and no ack -> data_8bit goes 125 then 75 and the flag stays 1; overrun_cnt=1 with FM_PEAK_OVERRUN_CNT_EN defined.
- Simultaneous events: byte_received on the same edge as a window end with peak 800 -> data_8bit=100, flag stays 1, overrun_cnt unchanged; repeat with peak 100 -> flag=0.
- Reset mid-window: after 100 samples of value 1500, assert rst for 1 cycle, then send 256 zeros -> no flag, data_8bit=0, and win_done exactly 256 valid samples after reset.
